// File: rtl/relu_backward_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : relu_backward_ctrl
// Purpose  : Sequences one ReLU-backward layer pass: issues source reads,
//            tracks them through the read+datapath pipeline, emits writes,
//            checks returned layer tags.
// Revision : 1.0
// ============================================================================
module relu_backward_ctrl #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter int DP_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_vec,
  input  logic [7:0]        layer_id,
  input  logic              in_rdy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        dp_id,
  input  logic [7:0]        dp_id_out,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int                 c_DEPTH = RD_LAT + DP_LAT;
  localparam logic [c_DEPTH-1:0] c_TOP   = c_DEPTH'(1) << (c_DEPTH - 1);
  localparam logic [ADDR_W-1:0]  c_ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_rst_sync;
  logic                w_rst_n;
  logic                r_start;
  logic [ADDR_W-1:0]   r_req_num;
  logic [7:0]          r_req_id;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_num;
  logic [7:0]          r_lid;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [c_DEPTH-1:0]  r_vld;
  logic [ADDR_W-1:0]   r_pa [c_DEPTH];
  logic                w_rd;
  logic                w_last;
  logic                w_mis;
  logic                w_drained;

  // Assertion is immediate; release is retimed so no flop leaves reset mid-cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Requests are captured only while idle, so starts in any other state vanish.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_start   <= 1'b0;
      r_req_num <= '0;
      r_req_id  <= '0;
    end else begin
      r_start <= start && (r_state == S_IDLE);
      if (start && (r_state == S_IDLE)) begin
        r_req_num <= num_vec;
        r_req_id  <= layer_id;
      end
    end
  end

  assign w_rd      = (r_state == S_ISSUE) && in_rdy;
  assign w_last    = w_rd && (r_cnt == (r_num - c_ONE));
  assign w_mis     = r_vld[c_DEPTH-1] && (dp_id_out != r_lid);
  // Only the final stage may be occupied: it retires this cycle.
  assign w_drained = ((r_vld & ~c_TOP) == '0);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_num   <= '0;
      r_lid   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_mis) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (r_start) begin
            r_num  <= r_req_num;
            r_lid  <= r_req_id;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (r_req_num != '0) begin
              r_state <= S_ISSUE;
            end else begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (w_rd) begin
            r_cnt <= r_cnt + c_ONE;
            if (w_last) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_drained) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_lid   <= '0;
          r_cnt   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_pa[i] <= '0;
      end
    end else begin
      r_vld[0] <= w_rd;
      r_pa[0]  <= r_cnt;
      for (int i = c_DEPTH - 1; i > 0; i--) begin
        r_vld[i] <= r_vld[i-1];
        r_pa[i]  <= r_pa[i-1];
      end
    end
  end

  assign rd_en   = w_rd;
  assign rd_addr = r_cnt;
  assign wr_en   = r_vld[c_DEPTH-1];
  assign wr_addr = r_pa[c_DEPTH-1];
  assign dp_id   = r_lid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign err     = r_err | w_mis;

endmodule
`default_nettype wire

// File: doc/relu_backward_ctrl.md
RELU_BACKWARD_CTRL -- requirements
Module: relu_backward_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, vector address/count width.
REQ-002 SHALL have parameter RD_LAT, default 1, cycles from rd_en to source data valid at datapath input.
REQ-003 SHALL have parameter DP_LAT, default 1, ReLU-backward datapath latency in cycles.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  single-cycle request to run one layer pass.
REQ-007 SHALL have port num_vec  input  ADDR_W  number of WIDTH-float vectors in the pass, sampled on accepted start.
REQ-008 SHALL have port layer_id  input  8  layer tag, sampled on accepted start.
REQ-009 SHALL have port in_rdy  input  1  source buffer can accept a read this cycle.
REQ-010 SHALL have port rd_en  output  1  read strobe to source buffer.
REQ-011 SHALL have port rd_addr  output  ADDR_W  source vector index.
REQ-012 SHALL have port dp_id  output  8  tag driven to datapath id input.
REQ-013 SHALL have port dp_id_out  input  8  tag returned by datapath.
REQ-014 SHALL have port wr_en  output  1  result write strobe to gradient buffer.
REQ-015 SHALL have port wr_addr  output  ADDR_W  destination vector index.
REQ-016 SHALL have ports busy, done, err  output  1 each  pass active / one-cycle completion pulse / sticky tag mismatch.

Function
REQ-017 SHALL implement FSM IDLE, ISSUE, DRAIN, FIN.
REQ-018 SHALL in IDLE accept start, latch num_vec and layer_id, clear err, set issue counter 0; next state ISSUE if num_vec>0, else FIN.
REQ-019 SHALL ignore start in any state other than IDLE.
REQ-020 SHALL in ISSUE assert rd_en with rd_addr=issue counter exactly in cycles where in_rdy=1, incrementing counter per read.
REQ-021 SHALL stall (rd_en=0, counter held) while in_rdy=0; no timeout.
REQ-022 SHALL leave ISSUE for DRAIN on the cycle the read with rd_addr=num_vec-1 is issued.
REQ-023 SHALL carry each read through a valid/address shift register of depth RD_LAT+DP_LAT, asserting wr_en with wr_addr equal to that read's rd_addr exactly RD_LAT+DP_LAT cycles after its rd_en.
REQ-024 SHALL produce writes in address order, one per issued read, no drops or duplicates; writes have no backpressure.
REQ-025 SHALL drive dp_id=latched layer_id while busy, 0 in IDLE.
REQ-026 SHALL compare dp_id_out with latched layer_id on every wr_en cycle and set err on mismatch; err holds until next accepted start or reset.
REQ-027 SHALL remain in DRAIN until shift register empty, then enter FIN.
REQ-028 SHALL in FIN assert done for exactly one cycle and return to IDLE next cycle.
REQ-029 SHALL assert busy in ISSUE, DRAIN, FIN; deassert in IDLE.
REQ-030 SHALL treat num_vec=0 as empty pass: no rd_en, no wr_en, done pulse two cycles after start.
REQ-031 SHALL support num_vec=2^ADDR_W-1 with no counter wrap inside a pass.
REQ-032 SHALL make the cycle after done accept a new start (back-to-back passes, no overlap of writes).

Reset
REQ-033 SHALL on reset low immediately force IDLE, clear counters and shift register, and drive rd_en, wr_en, busy, done, err low, rd_addr, wr_addr, dp_id zero.
REQ-034 SHALL on reset mid-pass discard all in-flight reads; no wr_en after reset release until a new pass.
REQ-035 SHALL synchronise reset deassertion to clk; first start is accepted no earlier than first rising edge after release.

Verification
REQ-036 SHALL cover: start, num_vec=4, layer_id=0x12, in_rdy=1 -> rd_addr 0..3 on consecutive cycles, wr_addr 0..3 two cycles later, done one cycle after last write, err=0.
REQ-037 SHALL cover: num_vec=5, in_rdy toggled 1,0,0,1,... -> exactly 5 reads, each write 2 cycles after its read, order preserved.
REQ-038 SHALL cover: num_vec=0 -> no rd_en/wr_en, busy high 1 cycle, done 2 cycles after start.
REQ-039 SHALL cover: dp_id_out forced 0x13 on third write with layer_id=0x12 -> err rises that cycle and stays high through done and IDLE until next start.
REQ-040 SHALL cover: reset low after 2 of 8 reads -> outputs zero immediately, no subsequent wr_en; new pass num_vec=3 completes normally.
REQ-041 SHALL cover: start asserted during DRAIN and again in cycle after done -> first ignored, second begins new pass.
